reg_scoreboard: RTL
===================

# reg_scoreboard

Register-write scoreboard for the 5-stage LoongArch pipeline. It replaces stage-by-stage destination comparison with per-register pending-write counters. Every architectural register has a counter that increments when a writing instruction issues from ID to EXE and decrements when that instruction commits in WB. ID stalls while any source register it reads has a pending write. The block sits beside the ID stage; it takes issue information from ID, commit information from WB, and a flush from the exception/branch unit.

## Interface
Parameters:
- NREG, 32, number of architectural registers (r0 included, never tracked)
- CNT_W, 2, counter width; max in-flight writers per register = 2^CNT_W−1 = 3

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- ds_valid  in  1  ID holds a valid instruction
- ds_rj  in  5  source register j
- ds_rk  in  5  source register k
- ds_is_imm  in  1  instruction does not read rk
- ds_rf_we  in  1  instruction writes a register
- ds_rd  in  5  destination register
- es_allowin  in  1  EXE accepts an instruction this cycle
- ws_commit  in  1  WB writes the register file this cycle
- ws_dest  in  5  WB destination register
- flush  in  1  kill all instructions in ID/EXE/MEM
- ds_stall  out  1  ID must hold (combinational)
- busy_mask  out  NREG  bit i = counter[i] != 0; bit 0 always 0
- sb_err  out  1  sticky protocol-error flag

## Operation
- issue = ds_valid & ~ds_stall & es_allowin & ~flush.
- inc[i] = issue & ds_rf_we & (ds_rd == i) & (i != 0).
- dec[i] = ws_commit & (ws_dest == i) & (i != 0).
- Counter update per register, applied in this priority:
  - reset → 0.
  - flush → 0. This covers every register. A WB commit in the same cycle is consumed, and the ID instruction is discarded.
  - inc & dec → unchanged.
  - inc only → +1.
  - dec only → −1.
- ds_stall = ds_valid & (raw_j | raw_k | waw_full).
  - raw_j = (ds_rj != 0) & busy[ds_rj].
  - raw_k = ~ds_is_imm & (ds_rk != 0) & busy[ds_rk].
  - waw_full = ds_rf_we & (ds_rd != 0) & (counter[ds_rd] == max).
- ds_stall uses registered counters only. There is no same-cycle WB bypass. The register file is written at the WB edge and is readable by ID the next cycle.
- sb_err is set on either of these conditions, and stays set until reset:
  - dec while the counter is 0 (commit with no matching issue), with no flush that cycle;
  - inc while the counter is at max. The stall logic should make this unreachable; it indicates a bad es_allowin/stall interaction.
- On an error the counter saturates: it stays at 0 or at max. It does not wrap.
- r0 is never counted. Writes to r0 are ignored, and reads of r0 never stall.

## Timing
- Reset values:
  - all counters 0
  - busy_mask = 0
  - sb_err = 0
  - ds_stall = 0 if ds_valid = 0; otherwise it depends only on waw_full, which is 0 after reset.
- Counter update latency: 1 cycle. A change in cycle N is visible in busy_mask and ds_stall in cycle N+1.
- Back-to-back dependent instructions:
  - Producer issues in cycle N; the consumer in ID sees busy from N+1.
  - The producer commits in WB in cycle N+3; the consumer unstalls in N+4.
- Flush takes effect at the edge. The cycle after a flush has all counters 0 and no stall.
- If reset and flush are asserted together, reset governs; the results are identical.
- If es_allowin = 0, there is no issue and no inc, whatever ds_stall is.

## Structure
- Add NREG, CNT_W and the register-index width (5) to DEFINE.vh. Also define RF_ADDR_W there, and the packed ID-to-scoreboard bus DS_TO_SB_WD = {ds_is_imm, ds_rf_we, ds_rd, ds_rj, ds_rk} = 17 bits.
- Sub-module sb_counter: one saturating up/down counter of width CNT_W.
  - Inputs: clk, reset, clr, inc, dec.
  - Outputs: cnt, busy, ovf, unf.
  - Instantiated NREG−1 times from a generate loop; r0 is tied off.
- The top level contains the decoders, the stall logic and the sticky error register.

## Test plan
- Reset, then ds_valid=1, rj=5, rk=6, is_imm=0, rf_we=0 → ds_stall=0, busy_mask=0, sb_err=0.
- Dependency on r3:
  - Cycle 0: issue rd=3 with es_allowin=1 → busy_mask[3]=1 in cycle 1.
  - Consumer with rj=3 is held, ds_stall=1, through the commit cycle: ws_commit=1, ws_dest=3 in cycle 3.
  - ds_stall=0 in cycle 4.
- Consumer reads rk=3 with is_imm=1 while r3 is busy → ds_stall=0. The same consumer with rj=0 and r0 "written" → no stall, busy_mask[0]=0.
- WAW saturation on r7:
  - Issue rd=7 three times with no commit → counter=3.
  - A fourth writer rd=7 → ds_stall=1, sb_err stays 0.
  - One commit to r7 → counter=2; the fourth writer issues next cycle.
- Simultaneous events:
  - Issue rd=9 and commit ws_dest=9 in the same cycle, with counter=1 → stays 1.
  - Flush with counters r4=2, r9=1 plus a same-cycle commit → all 0 next cycle, sb_err=0.
- Commit ws_dest=12 while counter[12]=0 → sb_err=1 next cycle and stays 1. counter[12] stays 0. Reset clears sb_err.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizes and the packed ID-to-scoreboard record for the register-write scoreboard.
package reg_scoreboard_pkg;
  localparam int NREG        = 32;
  localparam int CNT_W       = 2;
  localparam int REG_W       = 5;
  localparam int RF_ADDR_W   = REG_W;
  localparam int DS_TO_SB_WD = 17;

  // Field order matches {ds_is_imm, ds_rf_we, ds_rd, ds_rj, ds_rk}.
  typedef struct packed {
    logic                 is_imm;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rj;
    logic [RF_ADDR_W-1:0] rk;
  } ds_to_sb_t;

  function automatic logic [CNT_W-1:0] cnt_max();
    return {CNT_W{1'b1}};
  endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/commit/flush signals between the pipeline (master) and the scoreboard (slave).
// Handshake: an ID instruction issues on a rising edge when ds_valid & ~ds_stall & es_allowin & ~flush.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;
  logic                 ds_valid;
  logic [RF_ADDR_W-1:0] ds_rj;
  logic [RF_ADDR_W-1:0] ds_rk;
  logic                 ds_is_imm;
  logic                 ds_rf_we;
  logic [RF_ADDR_W-1:0] ds_rd;
  logic                 es_allowin;
  logic                 ws_commit;
  logic [RF_ADDR_W-1:0] ws_dest;
  logic                 flush;
  logic                 ds_stall;
  logic [NREG-1:0]      busy_mask;
  logic                 sb_err;

  modport master (
    output ds_valid, ds_rj, ds_rk, ds_is_imm, ds_rf_we, ds_rd,
    output es_allowin, ws_commit, ws_dest, flush,
    input  ds_stall, busy_mask, sb_err
  );
  modport slave (
    input  ds_valid, ds_rj, ds_rk, ds_is_imm, ds_rf_we, ds_rd,
    input  es_allowin, ws_commit, ws_dest, flush,
    output ds_stall, busy_mask, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         ovf,
  output logic         unf
);
  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Errors hold the counter at its rail instead of wrapping.
  assign ovf  = inc & ~dec & (cnt == MAX);
  assign unf  = dec & ~inc & (cnt == '0);
  assign busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && !unf) begin
      cnt <= cnt - W'(1);
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: issue/commit decoders, ID stall logic, sticky error flag.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);
  ds_to_sb_t       ds;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] ovf;
  logic [NREG-1:0] unf;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic            issue;
  logic            raw_j;
  logic            raw_k;
  logic            waw_full;
  logic            stall;
  logic            sb_err_q;

  assign ds = '{is_imm: sb.ds_is_imm, rf_we: sb.ds_rf_we, rd: sb.ds_rd,
                rj: sb.ds_rj, rk: sb.ds_rk};

  // r0 is hard-wired idle: never counted, never busy.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;
  assign ovf[0]  = 1'b0;
  assign unf[0]  = 1'b0;

  // Stall sees only registered counters; a same-cycle WB commit does not bypass.
  assign raw_j    = (ds.rj != '0) & busy[ds.rj];
  assign raw_k    = ~ds.is_imm & (ds.rk != '0) & busy[ds.rk];
  assign waw_full = ds.rf_we & (ds.rd != '0) & (cnt[ds.rd] == cnt_max());
  assign stall    = sb.ds_valid & (raw_j | raw_k | waw_full);
  assign issue    = sb.ds_valid & ~stall & sb.es_allowin & ~sb.flush;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < NREG; i++) begin
      inc[i] = issue & ds.rf_we & (ds.rd == RF_ADDR_W'(i));
      dec[i] = sb.ws_commit & (sb.ws_dest == RF_ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (sb.flush),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .cnt   (cnt[g]),
      .busy  (busy[g]),
      .ovf   (ovf[g]),
      .unf   (unf[g])
    );
  end

  // A commit swallowed by a flush is not an underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err_q <= 1'b0;
    end else if ((|ovf) || ((|unf) && !sb.flush)) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb.ds_stall  = stall;
  assign sb.busy_mask = busy;
  assign sb.sb_err    = sb_err_q;
endmodule
